branch_pc_unit: RTL
===================

// Module: branch_pc_unit
// PURPOSE
//  Owns the fetch PC register and the next-PC selection for the 5-stage MIPS core.
//  Sits directly downstream of the ID-stage equality comparator and consumes its result
//  (I_IGUAL) to resolve BEQ/BNE in ID.
//  Also resolves J/JAL/JR, drives IF/ID flush/hold and O_PC toward instruction memory.
//  Holds the PC while branch operands are not yet forwarded (FSM wait state).
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  WAIT_MAX  4              max consecutive operand-wait cycles before O_ERR is set
// PORTS
//  I_CLK      in   1   clock, rising edge
//  I_RST      in   1   synchronous reset, active-high
//  I_STALL    in   1   external hold from hazard unit (load-use, memory): freeze everything
//  I_BEQ      in   1   ID instruction is BEQ
//  I_BNE      in   1   ID instruction is BNE
//  I_J        in   1   ID instruction is J/JAL
//  I_JR       in   1   ID instruction is JR/JALR
//  I_IGUAL    in   1   comparator result: operands A == B
//  I_OPS_RDY  in   1   comparator operands valid (forwarded or from RF)
//  I_PC4_ID   in   32  PC+4 of the instruction currently in ID
//  I_IMM16    in   16  branch offset field (words)
//  I_JIDX     in   26  jump index field
//  I_JR_ADDR  in   32  forwarded rs value for JR
//  O_PC       out  32  current fetch address
//  O_PC4      out  32  O_PC + 4 (wraps mod 2^32)
//  O_TAKEN    out  1   redirect this cycle (branch taken or jump)
//  O_FLUSH    out  1   clear IF/ID on next edge
//  O_HOLD     out  1   hold IF/ID and PC (operand wait)
//  O_ERR      out  1   sticky: wait exceeded WAIT_MAX
// BEHAVIOUR
//  Reset: O_PC=RESET_PC; state=S_RUN; wait count=0; O_ERR=0.
//   All combinational outputs (O_TAKEN/O_FLUSH/O_HOLD) are 0 while I_RST=1.
//  Targets (mod 2^32):
//   BT = I_PC4_ID + {{14{I_IMM16[15]}}, I_IMM16, 2'b00}
//   JT = {I_PC4_ID[31:28], I_JIDX, 2'b00}
//   JRT = I_JR_ADDR
//  Priority per cycle: I_RST > I_STALL > redirect > sequential (PC <= PC+4).
//  I_STALL=1: PC, state, counter frozen; O_TAKEN=O_FLUSH=0; O_HOLD=0 (hazard unit owns hold).
//  FSM S_RUN:
//   - I_J or I_JR: PC <= JT/JRT, O_TAKEN=1, same cycle (JR needs I_OPS_RDY, else as branch wait).
//   - BEQ/BNE with I_OPS_RDY=1: taken = BEQ ? I_IGUAL : ~I_IGUAL; taken -> PC <= BT, O_TAKEN=1.
//   - BEQ/BNE/JR with I_OPS_RDY=0: O_HOLD=1, PC held, -> S_WAIT, count <= 1.
//  FSM S_WAIT:
//   - O_HOLD=1 while I_OPS_RDY=0; count++ (saturating).
//   - count reaching WAIT_MAX sets O_ERR (sticky until reset); FSM keeps waiting.
//   - I_OPS_RDY=1: resolve exactly as S_RUN in that cycle, -> S_RUN, count <= 0.
//  Latency: branch resolved in ID, 1 wrong-path fetch slot when taken; not-taken costs 0.
//  Only one of I_BEQ/I_BNE/I_J/I_JR may be set; multiple set = undefined (assertion).
//  Reset mid-S_WAIT returns to S_RUN with RESET_PC; no pending redirect survives.
// CONFIGURATION
//  MIPS_DELAY_SLOT_EN defined: architectural delay slot; O_FLUSH stays 0, slot instruction executes.
//  Undefined (default): O_FLUSH = O_TAKEN; wrong-path instruction squashed in IF/ID.
// STRUCTURE
//  mips_pkg: FSM state encodings (S_RUN, S_WAIT), RESET_PC default, opcode constants.
//  Sub-module branch_target_calc (combinational BT/JT/JRT plus select); FSM, PC register
//   and wait counter stay in top.
// TESTING
//  1. Reset then 3 idle clocks -> O_PC = 0,4,8,12; O_TAKEN=0.
//  2. BEQ, IGUAL=1, RDY=1, PC4_ID=0x100, IMM16=0x0003 -> next O_PC=0x10C, O_TAKEN=1, O_FLUSH=1 (no macro).
//  3. BNE, IGUAL=1 -> not taken, O_PC += 4. BEQ IMM16=0xFFFF, PC4_ID=0x100 -> O_PC=0xFC.
//  4. BEQ with RDY=0 for 2 cycles then 1 -> O_HOLD=1 two cycles, PC frozen, then redirect.
//     RDY=0 for WAIT_MAX cycles -> O_ERR=1 and stays 1.
//  5. I_STALL=1 concurrent with resolved taken BEQ -> no redirect that cycle.
//     Resolves after stall drops. J, PC4_ID=0xF000_0004, JIDX=0x10 -> O_PC=0xF000_0040.
//  6. Build with MIPS_DELAY_SLOT_EN: taken branch -> O_FLUSH=0. I_RST during S_WAIT -> O_PC=RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the MIPS fetch / branch-resolution slice.
//   - FSM state encodings for branch_pc_unit (S_RUN, S_WAIT)
//   - Default reset PC
//   - Redirect target select encoding used by branch_target_calc
//   - Opcode / funct constants of the control-transfer instructions the
//     decoder turns into I_BEQ / I_BNE / I_J / I_JR
// -----------------------------------------------------------------------------
package mips_pkg;

   // FSM states kept as plain 1-bit constants so older tools and checkers
   // can compare against them directly.
   localparam logic [0:0] S_RUN  = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Which computed target drives the redirect.
   typedef enum logic [1:0] {
      TGT_BR = 2'd0,   // PC-relative branch target
      TGT_J  = 2'd1,   // pseudo-direct jump target
      TGT_JR = 2'd2    // register jump target
   } tgt_sel_e;

   // Primary opcodes.
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;

   // SPECIAL funct codes.
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

endpackage

// File: rtl/branch_target_calc.sv
// -----------------------------------------------------------------------------
// branch_target_calc
//   Purely combinational redirect-target generation for the ID stage.
//   Ports:
//     pc4_id_i   [31:0]  PC+4 of the instruction in ID
//     imm16_i    [15:0]  branch word offset
//     jidx_i     [25:0]  jump index field
//     jr_addr_i  [31:0]  forwarded rs value
//     sel_i      tgt_sel_e  which target to output
//     target_o   [31:0]  selected redirect target (all sums wrap mod 2^32)
// -----------------------------------------------------------------------------
module branch_target_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc4_id_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] jidx_i,
   input  logic [31:0] jr_addr_i,
   input  tgt_sel_e    sel_i,
   output logic [31:0] target_o
);

   logic [31:0] bt;
   logic [31:0] jt;

   // Word offset, sign-extended and scaled to bytes.
   assign bt = pc4_id_i + {{14{imm16_i[15]}}, imm16_i, 2'b00};
   // Jump stays inside the 256 MB region of the delay-slot PC.
   assign jt = {pc4_id_i[31:28], jidx_i, 2'b00};

   always_comb begin
      target_o = bt;
      case (sel_i)
         TGT_J:   target_o = jt;
         TGT_JR:  target_o = jr_addr_i;
         default: target_o = bt;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// -----------------------------------------------------------------------------
// branch_pc_unit
//   Fetch PC register plus next-PC selection for the 5-stage MIPS core.
//   Resolves BEQ/BNE/J/JAL/JR/JALR in ID using the ID comparator result, and
//   holds PC and IF/ID while the comparator operands are not yet available.
//
//   Configuration macro: MIPS_DELAY_SLOT_EN
//     defined   -> architectural delay slot, O_FLUSH is always 0
//     undefined -> O_FLUSH follows O_TAKEN, wrong-path fetch is squashed
//
//   Ports:
//     I_CLK, I_RST         clock (rising edge), synchronous active-high reset
//     I_STALL              hazard-unit freeze: nothing advances, no redirect
//     I_BEQ/I_BNE/I_J/I_JR decoded control-transfer type in ID (one-hot or 0)
//     I_IGUAL, I_OPS_RDY   comparator result and operand-valid
//     I_PC4_ID, I_IMM16, I_JIDX, I_JR_ADDR   target ingredients
//     O_PC, O_PC4          fetch address and fetch address + 4
//     O_TAKEN              redirect this cycle
//     O_FLUSH              clear IF/ID on the next edge
//     O_HOLD               hold PC and IF/ID (operand wait)
//     O_ERR                sticky: operand wait reached WAIT_MAX cycles
//     O_STATE_DBG          current FSM state (S_RUN / S_WAIT)
//
//   Handshake: the branch in ID is "accepted" on the first non-stalled cycle
//   in which it does not need operands or I_OPS_RDY=1; until then O_HOLD=1
//   and the decoder must keep presenting the same instruction.
// -----------------------------------------------------------------------------
module branch_pc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          WAIT_MAX = 4
) (
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic        I_STALL,
   input  logic        I_BEQ,
   input  logic        I_BNE,
   input  logic        I_J,
   input  logic        I_JR,
   input  logic        I_IGUAL,
   input  logic        I_OPS_RDY,
   input  logic [31:0] I_PC4_ID,
   input  logic [15:0] I_IMM16,
   input  logic [25:0] I_JIDX,
   input  logic [31:0] I_JR_ADDR,
   output logic [31:0] O_PC,
   output logic [31:0] O_PC4,
   output logic        O_TAKEN,
   output logic        O_FLUSH,
   output logic        O_HOLD,
   output logic        O_ERR,
   output logic [0:0]  O_STATE_DBG
);

   localparam int            CW    = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CMAX  = CW'(WAIT_MAX);
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic [31:0]   pc_q, pc_d;
   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   logic          taken;
   logic          hold;
   logic          need_ops;
   logic [31:0]   target;
   tgt_sel_e      sel;

   assign sel = I_JR ? TGT_JR : (I_J ? TGT_J : TGT_BR);

   branch_target_calc u_tgt (
      .pc4_id_i  (I_PC4_ID),
      .imm16_i   (I_IMM16),
      .jidx_i    (I_JIDX),
      .jr_addr_i (I_JR_ADDR),
      .sel_i     (sel),
      .target_o  (target)
   );

   assign O_PC4    = pc_q + 32'd4;
   assign need_ops = I_BEQ | I_BNE | I_JR;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      taken   = 1'b0;
      hold    = 1'b0;
      if (!I_STALL) begin
         // In S_WAIT we keep holding on a missing operand even if the decode
         // flags flicker; the held instruction is by definition a waiter.
         if (!I_OPS_RDY && (need_ops || state_q == S_WAIT)) begin
            hold    = 1'b1;
            state_d = S_WAIT;
            if (state_q == S_RUN) begin
               cnt_d = C_ONE;
            end else if (cnt_q < CMAX) begin
               cnt_d = cnt_q + C_ONE;
            end
            if (cnt_d >= CMAX) begin
               err_d = 1'b1;
            end
         end else begin
            state_d = S_RUN;
            cnt_d   = '0;
            taken   = I_J | I_JR | (I_BEQ & I_IGUAL) | (I_BNE & ~I_IGUAL);
            pc_d    = taken ? target : O_PC4;
         end
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         pc_q    <= RESET_PC;
         state_q <= S_RUN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign O_PC        = pc_q;
   assign O_ERR       = err_q;
   assign O_STATE_DBG = state_q;
   assign O_TAKEN     = taken & ~I_RST;
   assign O_HOLD      = hold & ~I_RST;
`ifdef MIPS_DELAY_SLOT_EN
   // Slot instruction is architecturally executed, never squashed.
   assign O_FLUSH     = 1'b0;
`else
   assign O_FLUSH     = taken & ~I_RST;
`endif

   // Decoder contract: at most one control-transfer flag per cycle.
   a_onehot_ctl : assert property (@(posedge I_CLK) disable iff (I_RST)
      $onehot0({I_BEQ, I_BNE, I_J, I_JR}));

endmodule
